// File: rtl/uart_rx_if.sv
// Line and parallel-side signals of the 8N1 UART receiver.
// The receiver uses the slave modport; the line driver / byte consumer uses master.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data_out;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  modport master (output rx, input data_out, rx_done, frame_err, busy);
  modport slave  (input rx, output data_out, rx_done, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, centre sampling at clk_per_bit clocks per bit.
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote around each sample point, decided one cycle later.
module uart_rx #(
  parameter int clk_per_bit = 87
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave bus
);
  localparam logic [7:0] P_LAST = 8'(clk_per_bit - 1);
  localparam logic [7:0] H_LAST = 8'(clk_per_bit / 2 - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [7:0] DEC_OFS = 8'd1;
`else
  localparam logic [7:0] DEC_OFS = 8'd0;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t     state;
  logic       rx_meta, rx_s;
  logic [7:0] clk_count, shift_reg, samp_cnt;
  logic [2:0] bit_idx;
  logic       wait_high, decide, bit_val;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end

  assign samp_cnt = (state == START) ? H_LAST : P_LAST;
  assign decide   = (clk_count == samp_cnt + DEC_OFS);

`ifdef UART_RX_MAJORITY_EN
  logic maj_a, maj_b;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      maj_a <= 1'b1;
      maj_b <= 1'b1;
    end else begin
      if (clk_count == samp_cnt - 8'd1) maj_a <= rx_s;
      if (clk_count == samp_cnt)        maj_b <= rx_s;
    end

  assign bit_val = (maj_a & maj_b) | (maj_a & rx_s) | (maj_b & rx_s);
`else
  assign bit_val = rx_s;
`endif

  // Counter restarts at DEC_OFS after a decision so later sample points keep a one-cycle
  // shift instead of accumulating one cycle per bit in majority mode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      clk_count     <= '0;
      bit_idx       <= '0;
      shift_reg     <= '0;
      wait_high     <= 1'b0;
      bus.data_out  <= '0;
      bus.rx_done   <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.rx_done   <= 1'b0;
      bus.frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_s) wait_high <= 1'b0;
          else if (!wait_high) begin
            state     <= START;
            clk_count <= '0;
            bus.busy  <= 1'b1;
          end
        end
        START: begin
          if (decide) begin
            if (!bit_val) begin
              state     <= DATA;
              clk_count <= DEC_OFS;
              bit_idx   <= '0;
            end else begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
          end else clk_count <= clk_count + 8'd1;
        end
        DATA: begin
          if (decide) begin
            shift_reg <= {bit_val, shift_reg[7:1]};
            clk_count <= DEC_OFS;
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else clk_count <= clk_count + 8'd1;
        end
        STOP: begin
          if (decide) begin
            state     <= IDLE;
            bus.busy  <= 1'b0;
            clk_count <= '0;
            if (bit_val) begin
              bus.data_out <= shift_reg;
              bus.rx_done  <= 1'b1;
            end else begin
              // A break line must go high before the next start edge is trusted.
              bus.frame_err <= 1'b1;
              wait_high     <= 1'b1;
            end
          end else clk_count <= clk_count + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: random and directed 8N1 frames against a byte-queue model.
module tb_uart_rx;
  localparam int P = 87;
  localparam int H = P / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  // rx fall -> two synchronizer edges -> leave IDLE, then H + 9 bit periods to the stop decision.
  localparam int DONE_LAT = 3 + H + 9 * P + MAJ;

  logic clk = 1'b0;
  logic reset = 1'b1;
  uart_rx_if bus();

  uart_rx #(.clk_per_bit(P)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int cyc = 0;
  int vectors = 0, miscompares = 0;
  int done_cnt = 0, ferr_cnt = 0, both_cnt = 0, last_done_cyc = 0;
  logic [7:0] done_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (!reset) begin
      if (bus.rx_done) begin
        done_q.push_back(bus.data_out);
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (bus.frame_err) ferr_cnt++;
      if (bus.rx_done && bus.frame_err) both_cnt++;
    end

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); bus.rx = 1'b1; end
  endtask

  task automatic line_bit(input logic v, input int glitch_at);
    for (int i = 0; i < P; i++) begin
      @(negedge clk);
      bus.rx = (i == glitch_at) ? ~v : v;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch_bit,
                            input int rst_bit, output int fall);
    for (int i = 0; i < P; i++) begin
      @(negedge clk);
      if (i == 0) fall = cyc;
      bus.rx = 1'b0;
    end
    for (int k = 0; k < 8; k++) begin
      if (k == rst_bit) begin
        for (int i = 0; i < H; i++) begin @(negedge clk); bus.rx = b[k]; end
        @(negedge clk);
        reset = 1'b1;
        bus.rx = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        return;
      end
      line_bit(b[k], (k == glitch_bit) ? H : -1);
    end
    line_bit(stop, -1);
  endtask

  task automatic test_reset();
    bus.rx = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (bus.data_out !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h want 00", bus.data_out); end
    vectors++; if (bus.rx_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", bus.rx_done); end
    vectors++; if (bus.frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_ferr got %b want 0", bus.frame_err); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    idle(10);
  endtask

  task automatic test_single_frame();
    int d0, f0, fall;
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'hAB, 1'b1, -1, -1, fall);
    idle(P);
    vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL ab_pulses got %0d want 1", done_cnt - d0); end
    vectors++; if (bus.data_out !== 8'hAB) begin miscompares++; $display("FAIL ab_data got %h want ab", bus.data_out); end
    vectors++; if (last_done_cyc - fall !== DONE_LAT) begin miscompares++; $display("FAIL ab_latency got %0d want %0d", last_done_cyc - fall, DONE_LAT); end
    vectors++; if (ferr_cnt - f0 !== 0) begin miscompares++; $display("FAIL ab_ferr got %0d want 0", ferr_cnt - f0); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL ab_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    int f0, fall;
    f0 = ferr_cnt;
    done_q.delete();
    send_frame(8'h00, 1'b1, -1, -1, fall);
    send_frame(8'hFF, 1'b1, -1, -1, fall);
    idle(P);
    vectors++; if (done_q.size() !== 2) begin miscompares++; $display("FAIL b2b_count got %0d want 2", done_q.size()); end
    vectors++; if (done_q[0] !== 8'h00) begin miscompares++; $display("FAIL b2b_first got %h want 00", done_q[0]); end
    vectors++; if (done_q[1] !== 8'hFF) begin miscompares++; $display("FAIL b2b_second got %h want ff", done_q[1]); end
    vectors++; if (ferr_cnt - f0 !== 0) begin miscompares++; $display("FAIL b2b_ferr got %0d want 0", ferr_cnt - f0); end
  endtask

  task automatic test_random_stream();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int f0, fall;
    f0 = ferr_cnt;
    done_q.delete();
    for (int n = 0; n < 8; n++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, 1'b1, -1, -1, fall);
      idle($urandom_range(0, P / 2));
    end
    idle(P);
    vectors++; if (done_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL rand_count got %0d want %0d", done_q.size(), exp_q.size()); end
    for (int i = 0; i < 8; i++) begin
      vectors++; if (done_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rand_byte%0d got %h want %h", i, done_q[i], exp_q[i]); end
    end
    vectors++; if (ferr_cnt - f0 !== 0) begin miscompares++; $display("FAIL rand_ferr got %0d want 0", ferr_cnt - f0); end
  endtask

  task automatic test_false_start();
    int d0, f0, fall;
    d0 = done_cnt; f0 = ferr_cnt; fall = 0;
    for (int i = 0; i < 3 + H + MAJ + 4; i++) begin
      @(negedge clk);
      if (i == 0) fall = cyc;
      bus.rx = (i < 20) ? 1'b0 : 1'b1;
      if (i == 4) begin
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL glitch_busy_rise got %b want 1 (cyc %0d)", bus.busy, cyc - fall); end
      end
      if (i == 3 + H + MAJ) begin
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL glitch_busy_fall got %b want 0", bus.busy); end
      end
    end
    idle(2 * P);
    vectors++; if ((done_cnt - d0) + (ferr_cnt - f0) !== 0) begin miscompares++; $display("FAIL glitch_pulses got %0d want 0", (done_cnt - d0) + (ferr_cnt - f0)); end
  endtask

  task automatic test_frame_err();
    logic [7:0] b;
    int d0, f0, fall;
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b1, -1, -1, fall);
    send_frame(8'h5A, 1'b0, -1, -1, fall);
    repeat (3 * P) begin @(negedge clk); bus.rx = 1'b0; end
    vectors++; if (ferr_cnt - f0 !== 1) begin miscompares++; $display("FAIL ferr_pulses got %0d want 1", ferr_cnt - f0); end
    vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL ferr_done got %0d want 1", done_cnt - d0); end
    vectors++; if (bus.data_out !== 8'h3C) begin miscompares++; $display("FAIL ferr_data got %h want 3c", bus.data_out); end
    idle(2 * P);
    vectors++; if (ferr_cnt - f0 !== 1) begin miscompares++; $display("FAIL break_ferr got %0d want 1", ferr_cnt - f0); end
    b = 8'($urandom);
    send_frame(b, 1'b1, -1, -1, fall);
    idle(P);
    vectors++; if (done_cnt - d0 !== 2) begin miscompares++; $display("FAIL rearm_done got %0d want 2", done_cnt - d0); end
    vectors++; if (bus.data_out !== b) begin miscompares++; $display("FAIL rearm_data got %h want %h", bus.data_out, b); end
  endtask

  task automatic test_reset_mid_frame();
    int d0, f0, fall;
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'hC3, 1'b1, -1, 4, fall);
    idle(2 * P);
    vectors++; if ((done_cnt - d0) + (ferr_cnt - f0) !== 0) begin miscompares++; $display("FAIL rst_pulses got %0d want 0", (done_cnt - d0) + (ferr_cnt - f0)); end
    vectors++; if (bus.data_out !== 8'h00) begin miscompares++; $display("FAIL rst_data got %h want 00", bus.data_out); end
    send_frame(8'h81, 1'b1, -1, -1, fall);
    idle(P);
    vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL rst_next_done got %0d want 1", done_cnt - d0); end
    vectors++; if (bus.data_out !== 8'h81) begin miscompares++; $display("FAIL rst_next_data got %h want 81", bus.data_out); end
  endtask

  task automatic test_centre_glitch();
    logic [7:0] exp;
    int k, fall;
    k = $urandom_range(0, 7);
    exp = (MAJ != 0) ? 8'h00 : (8'h01 << k);
    send_frame(8'h00, 1'b1, k, -1, fall);
    idle(P);
    vectors++; if (bus.data_out !== exp) begin miscompares++; $display("FAIL centre_glitch bit%0d got %h want %h", k, bus.data_out, exp); end
  endtask

  task automatic test_no_overlap();
    vectors++; if (both_cnt !== 0) begin miscompares++; $display("FAIL done_ferr_overlap got %0d want 0", both_cnt); end
  endtask

  initial begin
    bus.rx = 1'b1;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_random_stream();
    test_false_start();
    test_frame_err();
    test_reset_mid_frame();
    test_centre_glitch();
    test_no_overlap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
